// File: rtl/aes_sbox_if.sv
// aes_sbox_if: valid/ready beat interface for the AES S-box engine
interface aes_sbox_if #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_inv;
  logic [8*LANES-1:0]   in_data;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [TAG_W-1:0]     out_tag;
  modport master (
    output in_valid, in_inv, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  in_valid, in_inv, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: pipelined multi-lane AES forward/inverse S-box with valid/ready flow control
module aes_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic       clk,
  input logic       rst_n,
  aes_sbox_if.slave s
);
  localparam int DW = 16 * LANES;
  if (STAGES < 1 || STAGES > 3 || LANES < 1) begin : g_bad_param
    $error("aes_sbox_pipe: STAGES must be 1..3 and LANES >= 1");
  end
  function automatic logic [7:0] f_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      r = b[i] ? r ^ x : r;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction
  function automatic logic [7:0] f_rot(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [7:0] f_aff(input logic [7:0] x);
    return x ^ f_rot(x, 1) ^ f_rot(x, 2) ^ f_rot(x, 3) ^ f_rot(x, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] f_iaff(input logic [7:0] x);
    return f_rot(x, 1) ^ f_rot(x, 3) ^ f_rot(x, 6) ^ 8'h05;
  endfunction
  function automatic logic [7:0] f_p16(input logic [7:0] a);
    logic [7:0] r;
    r = f_mul(a, a);
    r = f_mul(r, r);
    r = f_mul(r, r);
    return f_mul(r, r);
  endfunction
  function automatic logic [7:0] f_p14(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = f_mul(b, b);
    b4 = f_mul(b2, b2);
    b8 = f_mul(b4, b4);
    return f_mul(f_mul(b2, b4), b8);
  endfunction
  // a^-1 = a^16 * (a^17)^-1, where the norm a^17 lives in the GF(2^4) subfield and is inverted there as n^14
  function automatic logic [15:0] f_phase(input int p, input logic inv, input logic [15:0] w);
    logic [7:0] r;
    r = f_mul(w[15:8], w[7:0]);
    return p == 0 ? {8'h00, inv ? f_iaff(w[7:0]) : w[7:0]}
         : p == 1 ? {f_p16(w[7:0]), f_mul(f_p16(w[7:0]), w[7:0])}
         : p == 2 ? {w[15:8], f_p14(w[7:0])}
         : {8'h00, inv ? r : f_aff(r)};
  endfunction
  function automatic logic [DW-1:0] f_run(input logic inv, input logic [DW-1:0] d, input int lo, input int hi);
    logic [DW-1:0] r;
    logic [15:0]   w;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      w = d[16*l +: 16];
      for (int p = 0; p < 4; p++) w = (p >= lo && p <= hi) ? f_phase(p, inv, w) : w;
      r[16*l +: 16] = w;
    end
    return r;
  endfunction
  function automatic int f_lo(input int i);
    return i == 0 ? 0 : STAGES == 2 ? 2 : i == 1 ? 1 : 3;
  endfunction
  function automatic int f_hi(input int i);
    return i == STAGES - 1 ? 3 : STAGES == 2 ? 1 : i == 0 ? 0 : 2;
  endfunction
  function automatic logic [DW-1:0] f_in(input logic [8*LANES-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[16*l +: 16] = {8'h00, d[8*l +: 8]};
    return r;
  endfunction
  function automatic logic [8*LANES-1:0] f_out(input logic [DW-1:0] d);
    logic [8*LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[8*l +: 8] = d[16*l +: 8];
    return r;
  endfunction
  logic [STAGES-1:0] r_v, r_inv;
  logic [DW-1:0]     r_d   [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [STAGES-1:0] w_en, w_sv, w_si;
  logic [DW-1:0]     w_sd  [STAGES];
  logic [TAG_W-1:0]  w_st  [STAGES];
  // slot i may load when it or any slot downstream of it is empty, or the consumer takes the output
  always_comb begin
    w_en = '0;
    w_sv = '0;
    w_si = '0;
    w_sd = '{default: '0};
    w_st = '{default: '0};
    w_sv[0] = s.in_valid;
    w_si[0] = s.in_inv;
    w_sd[0] = f_in(s.in_data);
    w_st[0] = s.in_tag;
    for (int i = 0; i < STAGES; i++) w_en[i] = s.out_ready | ~&(r_v | STAGES'((1 << i) - 1));
    for (int i = 1; i < STAGES; i++) begin
      w_sv[i] = r_v[i-1];
      w_si[i] = r_inv[i-1];
      w_sd[i] = r_d[i-1];
      w_st[i] = r_tag[i-1];
    end
  end
  // each slot captures its upstream beat, running the datapath phases assigned to that cut
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v   <= '0;
      r_inv <= '0;
      r_d   <= '{default: '0};
      r_tag <= '{default: '0};
    end else
      for (int i = 0; i < STAGES; i++) begin
        r_v[i]   <= w_en[i] ? w_sv[i] : r_v[i];
        r_inv[i] <= w_en[i] ? w_si[i] : r_inv[i];
        r_d[i]   <= w_en[i] ? f_run(w_si[i], w_sd[i], f_lo(i), f_hi(i)) : r_d[i];
        r_tag[i] <= w_en[i] ? w_st[i] : r_tag[i];
      end
  assign s.in_ready  = w_en[0];
  assign s.out_valid = r_v[STAGES-1];
  assign s.out_data  = f_out(r_d[STAGES-1]);
  assign s.out_tag   = r_tag[STAGES-1];
endmodule

// File: tb/tb_aes_sbox_pipe.sv
// tb_aes_sbox_pipe: vector tables plus scoreboard checks of the pipelined AES S-box engine
module tb_aes_sbox_pipe;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } beat_t;
  typedef struct {
    logic        inv;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  aes_sbox_if #(.LANES(LANES), .TAG_W(TAG_W)) vif();
  aes_sbox_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(vif.slave)
  );
  logic [7:0] fsb [256];
  logic [7:0] isb [256];
  beat_t sb [$];
  int n_cmp = 0, n_bad = 0, cyc = 0, n_out = 0, first_out = -1, last_out = -1;
  bit held_v = 0;
  logic [35:0] held;
  vec_t vt [8];
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return r;
  endfunction
  function automatic logic [31:0] model(input logic inv, input logic [31:0] d);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = inv ? isb[d[8*l +: 8]] : fsb[d[8*l +: 8]];
    return r;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic inv, input logic [31:0] d, input logic [3:0] t, input bit rnd);
    bit ok;
    ok = 0;
    vif.in_valid = 1;
    vif.in_inv = inv;
    vif.in_data = d;
    vif.in_tag = t;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (rnd) vif.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = vif.in_ready;
      tick();
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask
  always @(negedge clk) begin : mon
    beat_t e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      held_v = 0;
    end else begin
      if (held_v) check("hold", {vif.out_valid, vif.out_tag, vif.out_data}, {1'b1, held});
      held_v = vif.out_valid & ~vif.out_ready;
      held = {vif.out_tag, vif.out_data};
      if (vif.out_valid && vif.out_ready) begin
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("sb_beat", {vif.out_tag, vif.out_data}, e);
        end
      end
      if (vif.in_valid && vif.in_ready) sb.push_back({vif.in_tag, model(vif.in_inv, vif.in_data)});
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] c, v, sx;
    bit got;
    vif.in_valid = 0;
    vif.in_inv = 0;
    vif.in_data = 0;
    vif.in_tag = 0;
    vif.out_ready = 1;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        sx[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      fsb[x] = sx;
    end
    for (int x = 0; x < 256; x++) isb[fsb[x]] = 8'(x);
    vt[0] = '{1'b0, 32'h00000000, 32'h63636363};
    vt[1] = '{1'b0, 32'h01015353, 32'h7C7CEDED};
    vt[2] = '{1'b1, 32'h636300ED, 32'h00005253};
    vt[3] = '{1'b0, 32'hCF4F3C09, 32'h8A84EB01};
    vt[4] = '{1'b1, 32'h8A84EB01, 32'hCF4F3C09};
    vt[5] = '{1'b0, 32'h09CF4F3C, 32'h018A84EB};
    vt[6] = '{1'b0, 32'hFF102000, 32'h16CAB763};
    vt[7] = '{1'b1, 32'h16CAB763, 32'hFF102000};
    repeat (2) tick();
    check("rst_out_valid", vif.out_valid, 0);
    check("rst_out_data", vif.out_data, 0);
    check("rst_out_tag", vif.out_tag, 0);
    check("rst_in_ready", vif.in_ready, 1);
    rst_n = 1;
    tick();
    n_out = 0;
    first_out = -1;
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 256; b++) begin
        logic [7:0] x;
        x = 8'(b);
        send(m[0], {x ^ 8'hA5, x ^ 8'h3C, x ^ 8'hF0, x}, x[3:0], 0);
      end
    vif.in_valid = 0;
    repeat (STAGES + 2) tick();
    check("exh_count", n_out, 512);
    check("exh_burst", last_out - first_out, 511);
    check("exh_drain", sb.size(), 0);
    for (int i = 0; i < 8; i++) begin
      send(vt[i].inv, vt[i].din, 4'(i), 0);
      vif.in_valid = 0;
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (vif.out_valid) begin
          got = 1;
          check($sformatf("vec%0d", i), vif.out_data, vt[i].dout);
        end
        tick();
      end
      if (!got) check("vec_timeout", 0, 1);
    end
    for (int k = 0; k < 16; k++) send(k[0], 32'h0, k[3:0], 0);
    vif.in_valid = 0;
    repeat (STAGES + 2) tick();
    check("alt_drain", sb.size(), 0);
    for (int k = 0; k < 1000; k++) send(1'($urandom_range(0, 1)), $urandom, k[3:0], 1);
    vif.in_valid = 0;
    vif.out_ready = 1;
    repeat (STAGES + 2) tick();
    check("rnd_drain", sb.size(), 0);
    vif.out_ready = 0;
    for (int k = 0; k < STAGES; k++) send(0, 32'h01020304 + k, 4'(k), 0);
    vif.in_valid = 1;
    vif.in_data = 32'hAAAAAAAA;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_in_ready", vif.in_ready, 0);
      check("stall_data", {vif.out_valid, vif.out_data}, {1'b1, model(0, 32'h01020304)});
      tick();
    end
    vif.in_valid = 0;
    vif.out_ready = 1;
    for (int k = 0; k <= STAGES; k++) begin
      @(negedge clk);
      check("stall_drain", vif.out_valid, k < STAGES);
      tick();
    end
    send(0, 32'h11223344, 4'h1, 0);
    send(1, 32'h55667788, 4'h2, 0);
    rst_n = 0;
    #1;
    check("mid_rst_valid", vif.out_valid, 0);
    check("mid_rst_data", vif.out_data, 0);
    check("mid_rst_ready", vif.in_ready, 1);
    vif.in_valid = 0;
    @(negedge clk);
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale", vif.out_valid, 0);
      tick();
    end
    send(0, 32'h53535353, 4'h5, 0);
    vif.in_valid = 0;
    for (int k = 0; k < STAGES; k++) begin
      @(negedge clk);
      check("latency", vif.out_valid, k == STAGES - 1);
      if (vif.out_valid) check("post_rst_53", {vif.out_tag, vif.out_data}, {4'h5, 32'hEDEDEDED});
      tick();
    end
    repeat (3) tick();
    check("final_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
